pipeline_controller: RTL and testbench

Parametrised successor to the CPU's stage sequencer. Generates the per-stage write enables, bubble/flush controls and architectural-state write strobes (PC, data RAM, register file) for an N-stage in-order integer pipeline. Runs either in sequential mode (one instruction in flight, one stage per cycle) or in overlapped pipelined mode with RAW-hazard stall and branch flush. Sits beside the datapath; it owns no data, only control.

---
 rtl/pipeline_controller_pkg.sv | 29 ++
 rtl/pipeline_controller_hazard_detector.sv | 34 +++
 rtl/pipeline_controller.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller: operating-mode encodings,
// stage indices for the default five-stage depth, and the per-cycle
// classification used to decode the control outputs.
package pipeline_controller_pkg;

    // Operating mode latched while reset is held.
    typedef enum logic {
        MODE_SEQUENTIAL = 1'b0,
        MODE_PIPELINED  = 1'b1
    } mode_e;

    // Stage indices for the default depth (STAGES = 5).
    localparam int STAGE_IF  = 0;
    localparam int STAGE_ID  = 1;
    localparam int STAGE_EX  = 2;
    localparam int STAGE_MEM = 3;
    localparam int STAGE_WB  = 4;

    // What the controller is doing in the current cycle; exactly one applies.
    typedef enum logic [2:0] {
        CYC_RESET,   // reset_n low: clear every pipeline register
        CYC_HALT,    // frozen: no enable, no strobe
        CYC_SEQ,     // sequential mode, token drives the enables
        CYC_RUN,     // pipelined, no hazard and no branch
        CYC_STALL,   // pipelined, RAW hazard holds IF/ID and bubbles ID/EX
        CYC_FLUSH    // pipelined, taken branch squashes the younger stages
    } cycle_e;

endpackage

// File: rtl/pipeline_controller_hazard_detector.sv
// RAW hazard detector: compares the two ID-stage sources against the
// destination registers of stages 2..STAGES-1. Register 0 never creates a
// hazard. The WB slot is included because the register file has no
// write-through.
module hazard_detector #(
    parameter int SLOTS      = 3,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0]       rs1_addr,
    input  logic [REG_ADDR_W-1:0]       rs2_addr,
    input  logic                        rs1_used,
    input  logic                        rs2_used,
    input  logic [SLOTS*REG_ADDR_W-1:0] dst_addr,
    input  logic [SLOTS-1:0]            dst_wren,
    output logic                        hazard
);

    logic [REG_ADDR_W-1:0] slot;

    // OR together a match from every writing, non-zero destination slot.
    always_comb begin
        hazard = 1'b0;
        slot   = '0;
        for (int j = 0; j < SLOTS; j++) begin
            slot = dst_addr[j*REG_ADDR_W +: REG_ADDR_W];
            if (dst_wren[j] && (slot != '0) &&
                ((rs1_used && (slot == rs1_addr)) ||
                 (rs2_used && (slot == rs2_addr)))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Stage sequencer for an N-stage in-order pipeline. Produces pipeline
// register enables/flushes and PC, RAM and register-file write strobes in
// either sequential (one instruction in flight) or pipelined mode with
// RAW stall and branch flush. All outputs are combinational from the token,
// the latched mode and the current inputs.
// Optional feature: define PIPELINE_PERF_COUNTERS_EN to build the cycle,
// stall and flush counters; otherwise those ports are tied to zero.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int STAGES       = 5,
    parameter int MEM_STAGE    = 3,
    parameter int BRANCH_STAGE = 3,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               mode,
    input  logic                               halt,
    input  logic [REG_ADDR_W-1:0]              id_rs1_addr,
    input  logic [REG_ADDR_W-1:0]              id_rs2_addr,
    input  logic                               id_rs1_used,
    input  logic                               id_rs2_used,
    input  logic [(STAGES-2)*REG_ADDR_W-1:0]   dst_addr,
    input  logic [STAGES-3:0]                  dst_wren,
    input  logic                               branch_taken,
    output logic                               pc_wren,
    output logic                               pc_redirect,
    output logic [STAGES-2:0]                  pipe_wren,
    output logic [STAGES-2:0]                  pipe_flush_n,
    output logic                               ram_wren,
    output logic                               reg_wren,
    output logic [31:0]                        cycle_count,
    output logic [31:0]                        stall_count,
    output logic [31:0]                        flush_count
);

    localparam logic [STAGES-1:0] TOK_FIRST = {{(STAGES-1){1'b0}}, 1'b1};

    mode_e             mode_q;
    logic [STAGES-1:0] tok;
    logic [STAGES-1:0] tok_next;
    logic              hazard;
    cycle_e            kind;

    hazard_detector #(
        .SLOTS      (STAGES-2),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detector (
        .rs1_addr (id_rs1_addr),
        .rs2_addr (id_rs2_addr),
        .rs1_used (id_rs1_used),
        .rs2_used (id_rs2_used),
        .dst_addr (dst_addr),
        .dst_wren (dst_wren),
        .hazard   (hazard)
    );

    // Mode is sampled only while reset is held, so it cannot change mid-run.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment keeps every register updating from
        // pre-edge values, independent of block ordering.
        if (!reset_n) begin
            mode_q <= mode_e'(mode);
        end
    end

    // Classify the cycle; priority is reset, halt, mode, branch, hazard.
    always_comb begin
        kind = CYC_RUN;
        if (!reset_n) begin
            kind = CYC_RESET;
        end else if (halt) begin
            kind = CYC_HALT;
        end else if (mode_q == MODE_SEQUENTIAL) begin
            kind = CYC_SEQ;
        end else if (branch_taken) begin
            kind = CYC_FLUSH;
        end else if (hazard) begin
            kind = CYC_STALL;
        end
    end

    // Token rotates one stage per active sequential cycle, WB wraps to IF.
    always_comb begin
        tok_next = tok;
        if (kind == CYC_SEQ) begin
            tok_next = {tok[STAGES-2:0], tok[STAGES-1]};
        end
    end

    // Token register, restarted at IF by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tok <= TOK_FIRST;
        end else begin
            tok <= tok_next;
        end
    end

    // Decode the cycle class into enables, flushes and strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_wren      = 1'b0;
        pc_redirect  = 1'b0;
        pipe_wren    = '0;
        pipe_flush_n = '1;
        ram_wren     = 1'b0;
        reg_wren     = 1'b0;
        case (kind)
            CYC_RESET: begin
                pipe_flush_n = '0;
            end
            CYC_HALT: begin
            end
            CYC_SEQ: begin
                pipe_wren = tok[STAGES-2:0];
                ram_wren  = tok[MEM_STAGE];
                reg_wren  = tok[STAGES-1];
                pc_wren   = tok[STAGES-1];
            end
            CYC_STALL: begin
                pipe_wren       = '1;
                pipe_wren[0]    = 1'b0;
                pipe_flush_n[1] = 1'b0;
                ram_wren        = 1'b1;
                reg_wren        = 1'b1;
            end
            CYC_FLUSH: begin
                pc_wren     = 1'b1;
                pc_redirect = 1'b1;
                pipe_wren   = '1;
                ram_wren    = 1'b1;
                reg_wren    = 1'b1;
                for (int i = 0; i < BRANCH_STAGE; i++) begin
                    pipe_flush_n[i] = 1'b0;
                end
            end
            default: begin
                pc_wren   = 1'b1;
                pipe_wren = '1;
                ram_wren  = 1'b1;
                reg_wren  = 1'b1;
            end
        endcase
    end

`ifdef PIPELINE_PERF_COUNTERS_EN
    logic [31:0] cycle_q;
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Free-running performance counters; halt freezes all but cycle_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (kind == CYC_STALL) begin
                stall_q <= stall_q + 32'd1;
            end
            if (kind == CYC_FLUSH) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign cycle_count = '0;
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller at the default parameters.
// Each cycle the expected outputs are derived from a small behavioural model
// and pushed when stimulus is applied, then popped and compared on the
// falling edge. The model advances on the rising edge.
module tb_pipeline_controller;

    localparam int STAGES = 5;
`ifdef PIPELINE_PERF_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [3:0]  pipe_wren;
        logic [3:0]  pipe_flush_n;
        logic        pc_wren;
        logic        pc_redirect;
        logic        ram_wren;
        logic        reg_wren;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] fls;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        mode;
    logic        halt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic [4:0]  d [3];
    logic [14:0] dst_addr;
    logic [2:0]  dst_wren;
    logic        branch_taken;
    logic        pc_wren;
    logic        pc_redirect;
    logic [3:0]  pipe_wren;
    logic [3:0]  pipe_flush_n;
    logic        ram_wren;
    logic        reg_wren;
    logic [31:0] cycle_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    assign dst_addr = {d[2], d[1], d[0]};

    pipeline_controller dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mode         (mode),
        .halt         (halt),
        .id_rs1_addr  (rs1),
        .id_rs2_addr  (rs2),
        .id_rs1_used  (u1),
        .id_rs2_used  (u2),
        .dst_addr     (dst_addr),
        .dst_wren     (dst_wren),
        .branch_taken (branch_taken),
        .pc_wren      (pc_wren),
        .pc_redirect  (pc_redirect),
        .pipe_wren    (pipe_wren),
        .pipe_flush_n (pipe_flush_n),
        .ram_wren     (ram_wren),
        .reg_wren     (reg_wren),
        .cycle_count  (cycle_count),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec;
    int    n_miss;
    exp_t  sb [$];
    int    m_pos;
    bit    m_mode;
    int    m_cyc;
    int    m_stl;
    int    m_fls;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic bit model_hazard();
        bit h = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (dst_wren[j] && d[j] != 5'd0 &&
                ((u1 && d[j] == rs1) || (u2 && d[j] == rs2))) h = 1'b1;
        end
        return h;
    endfunction

    // Expected outputs for the current model state and applied inputs.
    function automatic exp_t build_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.pipe_wren = 4'b0000; e.pipe_flush_n = 4'b1111;
        e.pc_wren = 1'b0; e.pc_redirect = 1'b0; e.ram_wren = 1'b0; e.reg_wren = 1'b0;
        e.cyc = CNT_EN ? m_cyc : 0;
        e.stl = CNT_EN ? m_stl : 0;
        e.fls = CNT_EN ? m_fls : 0;
        if (!reset_n) begin
            e.pipe_flush_n = 4'b0000;
        end else if (halt) begin
            // everything idle
        end else if (!m_mode) begin
            if (m_pos < STAGES - 1) e.pipe_wren = 4'(1 << m_pos);
            e.ram_wren = (m_pos == 3);
            e.pc_wren  = (m_pos == 4);
            e.reg_wren = (m_pos == 4);
        end else if (branch_taken) begin
            e.pipe_wren = 4'b1111; e.pipe_flush_n = 4'b1000;
            e.pc_wren = 1'b1; e.pc_redirect = 1'b1; e.ram_wren = 1'b1; e.reg_wren = 1'b1;
        end else if (model_hazard()) begin
            e.pipe_wren = 4'b1110; e.pipe_flush_n = 4'b1101;
            e.ram_wren = 1'b1; e.reg_wren = 1'b1;
        end else begin
            e.pipe_wren = 4'b1111;
            e.pc_wren = 1'b1; e.ram_wren = 1'b1; e.reg_wren = 1'b1;
        end
        return e;
    endfunction

    // One cycle: push expectation, compare at negedge, advance model at posedge.
    task automatic step(input string tag);
        exp_t e;
        sb.push_back(build_exp(tag));
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".pipe_wren"},    32'(pipe_wren),    32'(e.pipe_wren));
        check({e.tag, ".pipe_flush_n"}, 32'(pipe_flush_n), 32'(e.pipe_flush_n));
        check({e.tag, ".pc_wren"},      32'(pc_wren),      32'(e.pc_wren));
        check({e.tag, ".pc_redirect"},  32'(pc_redirect),  32'(e.pc_redirect));
        check({e.tag, ".ram_wren"},     32'(ram_wren),     32'(e.ram_wren));
        check({e.tag, ".reg_wren"},     32'(reg_wren),     32'(e.reg_wren));
        check({e.tag, ".cycle_count"},  cycle_count,       e.cyc);
        check({e.tag, ".stall_count"},  stall_count,       e.stl);
        check({e.tag, ".flush_count"},  flush_count,       e.fls);
        @(posedge clk);
        if (!reset_n) begin
            m_pos = 0; m_mode = mode; m_cyc = 0; m_stl = 0; m_fls = 0;
        end else begin
            m_cyc++;
            if (!halt) begin
                if (!m_mode) m_pos = (m_pos + 1) % STAGES;
                else if (branch_taken) m_fls++;
                else if (model_hazard()) m_stl++;
            end
        end
        #1;
    endtask

    task automatic set_src(input logic [4:0] a1, input logic b1, input logic [4:0] a2, input logic b2);
        rs1 = a1; u1 = b1; rs2 = a2; u2 = b2;
    endtask

    task automatic set_dst(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                           input logic [2:0] w);
        d[0] = a0; d[1] = a1; d[2] = a2; dst_wren = w;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        m_pos = 0; m_mode = 1'b0; m_cyc = 0; m_stl = 0; m_fls = 0;
        reset_n = 1'b0; mode = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        set_src(5'd0, 1'b0, 5'd0, 1'b0);
        set_dst(5'd0, 5'd0, 5'd0, 3'b000);

        // Reset in sequential mode.
        step("rst_seq0");
        step("rst_seq1");
        reset_n = 1'b1;

        // Sequential: 12 cycles, token walks IF..WB and wraps.
        for (int c = 0; c < 12; c++) step($sformatf("seq_c%0d", c + 1));

        // Token now at state 2: halt three cycles, then resume there.
        halt = 1'b1;
        for (int c = 0; c < 3; c++) step($sformatf("seq_halt%0d", c));
        halt = 1'b0;
        step("seq_resume_s2");

        // Hazard and branch inputs are ignored in sequential mode.
        set_src(5'd3, 1'b1, 5'd0, 1'b0);
        set_dst(5'd3, 5'd0, 5'd0, 3'b001);
        branch_taken = 1'b1;
        step("seq_ignore0");
        step("seq_ignore1");
        branch_taken = 1'b0;

        // Mode toggled while running has no effect until reset.
        mode = 1'b1;
        step("seq_mode_hi0");
        step("seq_mode_hi1");

        // Reset with mode high, enter pipelined mode.
        reset_n = 1'b0;
        step("rst_pipe");
        reset_n = 1'b1;
        set_src(5'd0, 1'b0, 5'd0, 1'b0);
        set_dst(5'd0, 5'd0, 5'd0, 3'b000);
        step("pipe_idle");

        // RAW hazard on stage-2 slot: stall.
        set_src(5'd3, 1'b1, 5'd0, 1'b0);
        set_dst(5'd3, 5'd0, 5'd0, 3'b001);
        step("pipe_stall_ex");
        step("pipe_stall_ex2");

        // Same hazard against register 0: no stall.
        set_src(5'd0, 1'b1, 5'd0, 1'b0);
        set_dst(5'd0, 5'd0, 5'd0, 3'b001);
        step("pipe_r0");

        // rs2 against the WB slot; then unused source and non-writing slot.
        set_src(5'd1, 1'b0, 5'd9, 1'b1);
        set_dst(5'd0, 5'd0, 5'd9, 3'b100);
        step("pipe_stall_wb");
        set_src(5'd9, 1'b0, 5'd1, 1'b1);
        step("pipe_unused");
        set_src(5'd7, 1'b1, 5'd0, 1'b0);
        set_dst(5'd0, 5'd7, 5'd0, 3'b001);
        step("pipe_nowren");

        // Branch together with a hazard: flush wins.
        set_src(5'd3, 1'b1, 5'd0, 1'b0);
        set_dst(5'd3, 5'd0, 5'd0, 3'b001);
        branch_taken = 1'b1;
        step("pipe_flush");

        // Halt overrides branch and hazard in pipelined mode.
        halt = 1'b1;
        step("pipe_halt");

        // Randomised pipelined traffic with a small register range.
        halt = 1'b0;
        for (int c = 0; c < 40; c++) begin
            set_src(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            set_dst(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            branch_taken = ($urandom_range(0, 5) == 0);
            halt = ($urandom_range(0, 7) == 0);
            step($sformatf("pipe_rand%0d", c));
        end

        // Reset mid-operation wins over halt and branch; return to sequential.
        halt = 1'b1; branch_taken = 1'b1; mode = 1'b0;
        reset_n = 1'b0;
        step("rst_mid");
        reset_n = 1'b1; halt = 1'b0; branch_taken = 1'b0;
        step("seq_again0");
        step("seq_again1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
